memwb_skid_stage: RTL and testbench

//  Parametrised MEM->WB pipeline stage. Replaces the plain enable-held register with a

---
 rtl/memwb_pkg.sv | 22 ++
 rtl/memwb_slot.sv | 35 +++
 rtl/memwb_skid_stage.sv | 95 +++++++++
 tb/tb_memwb_skid_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memwb_pkg.sv
// Shared definitions for the MEM->WB pipeline stage: default widths,
// side-band bit positions and the entry layout used by producers and consumers.
package memwb_pkg;

    localparam int MEMWB_DATA_W = 32;
    localparam int MEMWB_SIDE_W = 1;
    localparam int SIDE_IPWR    = 0;

    typedef struct packed {
        logic [MEMWB_DATA_W-1:0] data;
        logic [MEMWB_SIDE_W-1:0] side;
    } memwb_entry_t;

    function automatic memwb_entry_t mk_entry(input logic [MEMWB_DATA_W-1:0] d,
                                              input logic [MEMWB_SIDE_W-1:0] s);
        memwb_entry_t e;
        e.data = d;
        e.side = s;
        return e;
    endfunction

endpackage

// File: rtl/memwb_slot.sv
// One pipeline storage slot: valid flag plus data and side-band, with load and clear.
// Clear also zeroes the side-band so an empty slot can never present a write strobe.
module memwb_slot
    import memwb_pkg::*;
#(
    parameter int DATA_W = MEMWB_DATA_W,
    parameter int SIDE_W = MEMWB_SIDE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_d,
    input  logic [SIDE_W-1:0] side_d,
    output logic              valid_q,
    output logic [DATA_W-1:0] data_q,
    output logic [SIDE_W-1:0] side_q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            side_q  <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
            side_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= data_d;
            side_q  <= side_d;
        end
    end

endmodule

// File: rtl/memwb_skid_stage.sv
// MEM->WB stage with valid/ready handshake and a two-slot skid buffer (M drives the
// outputs, S absorbs one entry while M is stalled). in_ready comes straight from a flop.
module memwb_skid_stage
    import memwb_pkg::*;
#(
    parameter int DATA_W = MEMWB_DATA_W,
    parameter int SIDE_W = MEMWB_SIDE_W,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SIDE_W-1:0] out_side,
    output logic [CNT_W-1:0]  occupancy
);

    logic              m_valid, s_valid;
    logic [DATA_W-1:0] m_data, s_data;
    logic [SIDE_W-1:0] m_side, s_side;
    logic              m_load, m_clear, s_load, s_clear;
    logic [DATA_W-1:0] m_data_d;
    logic [SIDE_W-1:0] m_side_d;
    logic              acc, deq;

    assign acc = in_valid & ~s_valid;
    assign deq = m_valid & out_ready & ~hold;

    always_comb begin
        m_load   = 1'b0;
        m_clear  = 1'b0;
        s_load   = 1'b0;
        s_clear  = 1'b0;
        m_data_d = in_data;
        m_side_d = in_side;
        if (flush) begin
            m_clear = 1'b1;
            s_clear = 1'b1;
        end else if (s_valid) begin
            // S is full so nothing can be accepted; drain it into M in order.
            if (deq) begin
                m_load   = 1'b1;
                m_data_d = s_data;
                m_side_d = s_side;
                s_clear  = 1'b1;
            end
        end else if (!m_valid || deq) begin
            if (acc) begin
                m_load = 1'b1;
            end else if (deq) begin
                m_clear = 1'b1;
            end
        end else if (acc) begin
            s_load = 1'b1;
        end
    end

    memwb_slot #(.DATA_W(DATA_W), .SIDE_W(SIDE_W)) u_slot_m (
        .clk     (clk),
        .rst     (rst),
        .load    (m_load),
        .clear   (m_clear),
        .data_d  (m_data_d),
        .side_d  (m_side_d),
        .valid_q (m_valid),
        .data_q  (m_data),
        .side_q  (m_side)
    );

    memwb_slot #(.DATA_W(DATA_W), .SIDE_W(SIDE_W)) u_slot_s (
        .clk     (clk),
        .rst     (rst),
        .load    (s_load),
        .clear   (s_clear),
        .data_d  (in_data),
        .side_d  (in_side),
        .valid_q (s_valid),
        .data_q  (s_data),
        .side_q  (s_side)
    );

    assign in_ready  = ~s_valid;
    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_side  = m_side;
    assign occupancy = CNT_W'(m_valid) + CNT_W'(s_valid);

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Directed bench for memwb_skid_stage: a scoreboard queue filled on accepted inputs and
// drained by a monitor on every WB transfer, plus hand-computed point checks.
module tb_memwb_skid_stage;
    import memwb_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        hold;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [0:0]  in_side;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [0:0]  out_side;
    logic [1:0]  occupancy;

    int compared   = 0;
    int mismatched = 0;
    memwb_entry_t sb[$];

    memwb_skid_stage #(.DATA_W(32), .SIDE_W(1), .CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .hold      (hold),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_side   (in_side),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_side  (out_side),
        .occupancy (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: inputs are stable between posedge+1 and the next posedge, so the
    // falling edge sees exactly what the next rising edge will act on.
    initial begin
        memwb_entry_t e;
        forever begin
            @(negedge clk);
            if (!rst || flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready && !hold) begin
                    compared++;
                    if (sb.size() == 0) begin
                        mismatched++;
                        $display("FAIL sb_unexpected: got data=0x%0h side=%0d expected no output",
                                 out_data, out_side);
                    end else begin
                        e = sb.pop_front();
                        if (out_data !== e.data || out_side !== e.side) begin
                            mismatched++;
                            $display("FAIL sb_xfer: got data=0x%0h side=%0d expected data=0x%0h side=%0d",
                                     out_data, out_side, e.data, e.side);
                        end else begin
                            $display("xfer t=%0t data=0x%0h side=%0d", $time, out_data, out_side);
                        end
                    end
                end
                if (!out_valid) begin
                    compared++;
                    if (out_side !== 1'b0) begin
                        mismatched++;
                        $display("FAIL bubble_side: got %0d expected 0", out_side);
                    end
                end
                if (in_valid && in_ready)
                    sb.push_back(mk_entry(in_data, in_side));
            end
        end
    end

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        hold      = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        in_side   = 1'b1;
        out_ready = 1'b1;

        // 1: reset with in_valid asserted
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_occ",       {30'd0, occupancy}, 32'd0);
        chk("rst_out_data",  out_data,           32'd0);
        chk("rst_out_side",  {31'd0, out_side},  32'd0);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_side  = 1'b0;
        tick();

        // 2: streaming, one cycle latency, no bubbles
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h11 * i;
            tick();
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_data",  out_data, 32'h11 * i);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drained", {31'd0, out_valid}, 32'd0);

        // 3: backpressure fills M then S
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        chk("bp_occ1",    {30'd0, occupancy}, 32'd1);
        in_data = 32'hB;
        tick();
        chk("bp_occ2",    {30'd0, occupancy}, 32'd2);
        chk("bp_ready0",  {31'd0, in_ready},  32'd0);
        in_data = 32'hC;
        tick();
        chk("bp_m_holds", out_data,           32'hA);
        chk("bp_occ_sat", {30'd0, occupancy}, 32'd2);
        out_ready = 1'b1;
        tick();
        chk("bp_rel_b",   out_data,           32'hB);
        chk("bp_rel_rdy", {31'd0, in_ready},  32'd1);
        chk("bp_rel_occ", {30'd0, occupancy}, 32'd1);
        tick();
        chk("bp_rel_c",   out_data,           32'hC);
        in_valid = 1'b0;
        tick();
        chk("bp_empty",   {30'd0, occupancy}, 32'd0);

        // 4: flush with both slots full, then with room to accept
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1;
        tick();
        in_data = 32'h2;
        tick();
        chk("fl_occ2", {30'd0, occupancy}, 32'd2);
        in_data = 32'hDEAD;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_occ",   {30'd0, occupancy}, 32'd0);
        chk("fl_ready", {31'd0, in_ready},  32'd1);
        in_valid = 1'b1;
        in_data  = 32'h3;
        tick();
        in_data = 32'hDEAD;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_acc_drop", {30'd0, occupancy}, 32'd0);
        out_ready = 1'b1;
        tick();
        tick();
        chk("fl_no_dead", {31'd0, out_valid}, 32'd0);

        // 5: hold with side-band set
        hold     = 1'b1;
        in_valid = 1'b1;
        in_side  = 1'b1;
        in_data  = 32'h5A;
        tick();
        chk("hd_side1", {31'd0, out_side}, 32'd1);
        in_data = 32'h5B;
        tick();
        chk("hd_data1", out_data,           32'h5A);
        chk("hd_occ2",  {30'd0, occupancy}, 32'd2);
        chk("hd_rdy0",  {31'd0, in_ready},  32'd0);
        in_valid = 1'b0;
        tick();
        chk("hd_data2", out_data,           32'h5A);
        chk("hd_side2", {31'd0, out_side},  32'd1);
        hold = 1'b0;
        tick();
        chk("hd_next",  out_data,           32'h5B);
        chk("hd_side3", {31'd0, out_side},  32'd1);
        tick();
        chk("hd_bubble_v", {31'd0, out_valid}, 32'd0);
        chk("hd_bubble_s", {31'd0, out_side},  32'd0);

        // 6: reset while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h61;
        tick();
        in_data = 32'h62;
        tick();
        chk("mr_occ2", {30'd0, occupancy}, 32'd2);
        rst = 1'b0;
        tick();
        chk("mr_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_occ",   {30'd0, occupancy}, 32'd0);
        chk("mr_ready", {31'd0, in_ready},  32'd1);
        chk("mr_data",  out_data,           32'd0);
        chk("mr_side",  {31'd0, out_side},  32'd0);
        rst       = 1'b1;
        out_ready = 1'b1;
        in_side   = 1'b0;
        in_data   = 32'h70;
        tick();
        chk("mr_resume", out_data, 32'h70);
        in_valid = 1'b0;
        tick();
        tick();
        chk("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
